// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: producer-side circular buffer plus a
// small handshake FSM that issues one-cycle load strobes whenever the UART is idle.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  ovf_clr,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  txen,
  output logic [7:0]            din,
  input  logic                  txready,
  output logic                  busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SEND      = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [1:0]            state;
  logic                  push;
  logic                  pop;

  // Status comes only from registered count/state, so a write never frees room for itself.
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign busy  = (state != IDLE);
  assign push  = wr_en && !full;
  assign pop   = (state == IDLE) && !empty && txready;

  always_ff @(posedge clock) begin
    if (reset && push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      txen     <= 1'b0;
      din      <= 8'h00;
      state    <= IDLE;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A dropped write outranks a clear arriving on the same edge.
      if (wr_en && full)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;

      case (state)
        IDLE: begin
          if (pop) begin
            din   <= mem[rd_ptr];
            txen  <= 1'b1;
            state <= SEND;
          end
        end
        SEND: begin
          txen  <= 1'b0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!txready)
            state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (txready)
            state <= IDLE;
        end
        default: begin
          txen  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural UART that drops txready
// for a programmable number of cycles after each load strobe.
module tb_uart_tx_fifo;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ovf_clr = 1'b0;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       txen;
  logic [7:0] din;
  logic       txready;
  logic       busy;

  logic       uart_auto = 1'b0;
  logic       txready_man = 1'b1;
  logic       uart_ready = 1'b1;
  int         busy_len = 5;
  int         busy_cnt = 0;

  logic [7:0] sent_q [$];
  int         pulse_cycle_q [$];
  int         cycle = 0;
  logic       ready_at_edge = 1'b1;
  logic       prev_txen = 1'b0;
  int         long_pulses = 0;
  int         bad_pulses = 0;

  int         tests_run = 0;
  int         tests_failed = 0;

  assign txready = uart_auto ? uart_ready : txready_man;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .ovf_clr  (ovf_clr),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .txen     (txen),
    .din      (din),
    .txready  (txready),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cycle         <= cycle + 1;
    ready_at_edge <= txready;
  end

  // UART model and strobe monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (txen) begin
      if (prev_txen)
        long_pulses = long_pulses + 1;
      if (!ready_at_edge)
        bad_pulses = bad_pulses + 1;
      sent_q.push_back(din);
      pulse_cycle_q.push_back(cycle);
      if (uart_auto) begin
        uart_ready = 1'b0;
        busy_cnt   = busy_len;
      end
    end else if (uart_auto && !uart_ready) begin
      busy_cnt = busy_cnt - 1;
      if (busy_cnt <= 0)
        uart_ready = 1'b1;
    end
    prev_txen = txen;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run = tests_run + 1;
    if (actual !== expected) begin
      tests_failed = tests_failed + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] data);
    wr_en   = en;
    wr_data = data;
    tick();
  endtask

  task automatic waitPulses(input string tag, input int target, input int budget);
    int n = 0;
    while (sent_q.size() < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, sent_q.size(), target);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while ((busy || !txready) && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int guard;
    int i;

    // Reset state
    tick();
    tick();
    checkOutput("rst_count", count, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_txen", txen, 0);
    checkOutput("rst_din", din, 8'h00);
    checkOutput("rst_ovf", overflow, 0);

    // Single byte latency
    reset     = 1'b1;
    uart_auto = 1'b1;
    busy_len  = 5;
    tick();
    base = sent_q.size();
    applyStimulus(1'b1, 8'hA5);
    wr_en = 1'b0;
    checkOutput("a5_count_after_write", count, 1);
    checkOutput("a5_txen_at_write", txen, 0);
    tick();
    checkOutput("a5_txen", txen, 1);
    checkOutput("a5_din", din, 8'hA5);
    checkOutput("a5_count", count, 0);
    checkOutput("a5_busy", busy, 1);
    tick();
    checkOutput("a5_txen_drop", txen, 0);
    waitIdle("a5_idle", 50);

    // Three bytes against a slow UART
    busy_len = 100;
    base = sent_q.size();
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b1, 8'h02);
    applyStimulus(1'b1, 8'h03);
    wr_en = 1'b0;
    waitPulses("slow_pulses", base + 3, 600);
    if (sent_q.size() >= base + 3) begin
      checkOutput("slow_b0", sent_q[base], 8'h01);
      checkOutput("slow_b1", sent_q[base + 1], 8'h02);
      checkOutput("slow_b2", sent_q[base + 2], 8'h03);
      checkOutput("slow_gap1", pulse_cycle_q[base + 1] - pulse_cycle_q[base] >= 100, 1);
      checkOutput("slow_gap2", pulse_cycle_q[base + 2] - pulse_cycle_q[base + 1] >= 100, 1);
    end
    checkOutput("slow_ready_at_pulse", bad_pulses, 0);
    waitIdle("slow_idle", 300);

    // Fill to full, overflow and clear
    uart_auto   = 1'b0;
    txready_man = 1'b0;
    base = sent_q.size();
    for (int k = 0; k < 16; k++)
      applyStimulus(1'b1, 8'h10 + 8'(k));
    checkOutput("fill_full", full, 1);
    checkOutput("fill_count", count, 16);
    checkOutput("fill_ovf_before", overflow, 0);
    applyStimulus(1'b1, 8'hEE);
    checkOutput("drop_ovf", overflow, 1);
    checkOutput("drop_count", count, 16);
    ovf_clr = 1'b1;
    applyStimulus(1'b1, 8'hEF);
    checkOutput("ovf_set_wins", overflow, 1);
    applyStimulus(1'b0, 8'h00);
    ovf_clr = 1'b0;
    checkOutput("ovf_cleared", overflow, 0);
    checkOutput("no_pop_while_not_ready", sent_q.size(), base);

    // Write on the pop edge of a full FIFO is still dropped
    txready_man = 1'b1;
    applyStimulus(1'b1, 8'hDD);
    wr_en = 1'b0;
    checkOutput("popedge_count", count, 15);
    checkOutput("popedge_ovf", overflow, 1);
    checkOutput("popedge_txen", txen, 1);
    checkOutput("popedge_din", din, 8'h10);
    tick();
    txready_man = 1'b0;
    tick();
    busy_len  = 3;
    uart_auto = 1'b1;
    waitPulses("drain_pulses", base + 16, 800);
    if (sent_q.size() >= base + 16)
      for (int k = 0; k < 16; k++)
        checkOutput($sformatf("drain_b%0d", k), sent_q[base + k], 8'h10 + 8'(k));
    waitIdle("drain_idle", 100);
    checkOutput("drain_empty", empty, 1);

    // Stream 40 bytes, producer respects full
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checkOutput("stream_ovf_start", overflow, 0);
    busy_len = 2;
    base  = sent_q.size();
    i     = 0;
    guard = 0;
    while (i < 40 && guard < 3000) begin
      if (!full) begin
        applyStimulus(1'b1, 8'(i));
        i++;
      end else begin
        applyStimulus(1'b0, 8'h00);
      end
      guard++;
    end
    wr_en = 1'b0;
    checkOutput("stream_all_written", i, 40);
    waitPulses("stream_pulses", base + 40, 2000);
    if (sent_q.size() >= base + 40)
      for (int k = 0; k < 40; k++)
        checkOutput($sformatf("stream_b%0d", k), sent_q[base + k], 8'(k));
    checkOutput("stream_ovf", overflow, 0);
    checkOutput("stream_long_pulses", long_pulses, 0);
    waitIdle("stream_idle", 100);

    // Reset while waiting on the UART with bytes queued
    busy_len = 50;
    for (int k = 0; k < 6; k++)
      applyStimulus(1'b1, 8'h60 + 8'(k));
    wr_en = 1'b0;
    repeat (8) tick();
    checkOutput("midrst_count_before", count, 5);
    checkOutput("midrst_busy_before", busy, 1);
    reset = 1'b0;
    tick();
    checkOutput("midrst_count", count, 0);
    checkOutput("midrst_empty", empty, 1);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_txen", txen, 0);
    reset = 1'b1;
    base = sent_q.size();
    repeat (120) tick();
    checkOutput("midrst_no_pulse", sent_q.size(), base);
    applyStimulus(1'b1, 8'h77);
    wr_en = 1'b0;
    tick();
    checkOutput("after_rst_txen", txen, 1);
    checkOutput("after_rst_din", din, 8'h77);
    checkOutput("final_long_pulses", long_pulses, 0);
    checkOutput("final_bad_pulses", bad_pulses, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
